// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout: raster-order DRAM reader feeding a credit-controlled FWFT pixel FIFO.
// Ports: clk/rst_n (async active-low); i_enable runs scanout; o_mem_req/o_mem_addr/i_mem_gnt
// issue reads; i_mem_rvalid/i_mem_rdata return data in order; o_pix_* stream pixels with x/y,
// sof and eol under valid/ready; o_busy is high while the FSM is not idle.
// Define FB_SCANOUT_DOUBLE_BUFFER_EN to add i_front_sel and a per-frame buffer-select address MSB.
module framebuffer_scanout #(
  parameter int SCREEN_WIDTH = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int COLOR_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  localparam int ADDR_W = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_enable,
`ifdef FB_SCANOUT_DOUBLE_BUFFER_EN
  input  logic                   i_front_sel,
  output logic [ADDR_W:0]        o_mem_addr,
`else
  output logic [ADDR_W-1:0]      o_mem_addr,
`endif
  output logic                   o_mem_req,
  input  logic                   i_mem_gnt,
  input  logic                   i_mem_rvalid,
  input  logic [COLOR_WIDTH-1:0] i_mem_rdata,
  output logic                   o_pix_valid,
  input  logic                   i_pix_ready,
  output logic [COLOR_WIDTH-1:0] o_pix_data,
  output logic [9:0]             o_pix_x,
  output logic [9:0]             o_pix_y,
  output logic                   o_pix_sof,
  output logic                   o_pix_eol,
  output logic                   o_busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_WIDTH * SCREEN_HEIGHT - 1);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state;
  logic [ADDR_W-1:0] addr;
  logic [CW-1:0] outstanding, count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [COLOR_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [9:0] x, y;
  logic grant, push, pop, full, empty, last_x, last_y;
`ifdef FB_SCANOUT_DOUBLE_BUFFER_EN
  logic front;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) front <= 1'b0;
    else if ((state == IDLE && i_enable) || (state == DRAIN && outstanding == '0 && i_enable)) front <= i_front_sel;
  end
  always_comb o_mem_addr = {front, addr};
`else
  always_comb o_mem_addr = addr;
`endif
  // Credits count both buffered and in-flight pixels, so once a request is raised the
  // sum can only fall until it is granted: the request is never withdrawn.
  always_comb begin
    full = count == CW'(FIFO_DEPTH);
    empty = count == '0;
    o_mem_req = state == FETCH && ({1'b0, count} + {1'b0, outstanding} < (CW + 1)'(FIFO_DEPTH));
    grant = o_mem_req && i_mem_gnt;
    push = i_mem_rvalid && !full;
    pop = !empty && i_pix_ready;
    last_x = x == 10'(SCREEN_WIDTH - 1);
    last_y = y == 10'(SCREEN_HEIGHT - 1);
    o_pix_valid = !empty;
    o_pix_data = empty ? '0 : mem[rd_ptr];
    o_pix_x = x;
    o_pix_y = y;
    o_pix_sof = !empty && x == '0 && y == '0;
    o_pix_eol = !empty && last_x;
    o_busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      outstanding <= '0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      x <= '0;
      y <= '0;
    end else begin
      case (state)
        IDLE: if (i_enable) begin
          state <= FETCH;
          addr <= '0;
        end
        FETCH: if (grant) begin
          addr <= addr + ADDR_W'(1);
          if (addr == LAST_ADDR) state <= DRAIN;
        end
        DRAIN: if (outstanding == '0) begin
          state <= i_enable ? FETCH : IDLE;
          addr <= '0;
        end
        default: state <= IDLE;
      endcase
      outstanding <= outstanding + CW'(grant) - CW'(i_mem_rvalid);
      count <= count + CW'(push) - CW'(pop);
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      if (pop) begin
        x <= last_x ? '0 : x + 10'd1;
        if (last_x) y <= last_y ? '0 : y + 10'd1;
      end
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= i_mem_rdata;
`ifndef SYNTHESIS
  assert property (@(posedge clk) disable iff (!rst_n) !(i_mem_rvalid && full));
`endif
endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb_framebuffer_scanout: directed bench for framebuffer_scanout on a 4x2 screen with a 4-deep FIFO.
module tb_framebuffer_scanout;
  typedef struct packed {
    logic [31:0] d;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        sof;
    logic        eol;
  } pix_t;
  logic clk = 1'b0;
  logic rst_n, en, gnt, ready, rv, s0v;
  logic [31:0] rd;
  logic [2:0] s0d, addr;
  logic req, valid, sof, eol, busy;
  logic [31:0] data;
  logic [9:0] px, py;
  logic [2:0] gq[$];
  pix_t pq[$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  framebuffer_scanout #(.SCREEN_WIDTH(4), .SCREEN_HEIGHT(2), .COLOR_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(en), .o_mem_req(req), .o_mem_addr(addr), .i_mem_gnt(gnt),
    .i_mem_rvalid(rv), .i_mem_rdata(rd), .o_pix_valid(valid), .i_pix_ready(ready), .o_pix_data(data),
    .o_pix_x(px), .o_pix_y(py), .o_pix_sof(sof), .o_pix_eol(eol), .o_busy(busy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Logs this edge's grant and pop, then advances one clock; memory returns rdata=addr two edges after the grant.
  task automatic cycle();
    logic g;
    logic [2:0] a;
    g = req && gnt;
    a = addr;
    if (g) gq.push_back(a);
    if (valid && ready) pq.push_back('{data, px, py, sof, eol});
    @(posedge clk);
    #1;
    rv = s0v;
    rd = {29'd0, s0d};
    s0v = g;
    s0d = a;
  endtask
  task automatic chk_stream(input string tag, input int n);
    chk({tag, "_ngrant"}, 64'(gq.size()), 64'(n));
    chk({tag, "_npix"}, 64'(pq.size()), 64'(n));
    for (int i = 0; i < n && i < gq.size(); i++)
      chk($sformatf("%s_addr%0d", tag, i), 64'(gq[i]), 64'(i % 8));
    for (int i = 0; i < n && i < pq.size(); i++) begin
      pix_t e;
      e = '{32'(i % 8), 10'(i % 4), 10'((i / 4) % 2), (i % 8) == 0, (i % 4) == 3};
      chk($sformatf("%s_pix%0d", tag, i), 64'(pq[i]), 64'(e));
    end
  endtask
  task automatic clear();
    gq.delete();
    pq.delete();
  endtask
  initial begin
    rst_n = 1'b0; en = 1'b0; gnt = 1'b1; ready = 1'b1; rv = 1'b0; rd = '0; s0v = 1'b0; s0d = '0;
    cycle();
    cycle();
    chk("rst_req", 64'(req), 64'(0));
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_addr", 64'(addr), 64'(0));
    chk("rst_data", 64'(data), 64'(0));
    chk("rst_xy", 64'({px, py}), 64'(0));
    rst_n = 1'b1;
    en = 1'b1;
    cycle();
    cycle();
    cycle();
    chk("midfetch_granted", 64'(gq.size()), 64'(2));
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 64'(req), 64'(0));
    chk("midrst_valid", 64'(valid), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    cycle();
    cycle();
    chk("midrst_req_hold", 64'(req), 64'(0));
    chk("midrst_busy_hold", 64'(busy), 64'(0));
    clear();
    rv = 1'b0; s0v = 1'b0;
    rst_n = 1'b1;
    cycle();
    chk("rel_busy", 64'(busy), 64'(1));
    chk("rel_req", 64'(req), 64'(1));
    chk("rel_addr", 64'(addr), 64'(0));
    for (int k = 0; k < 300 && gq.size() < 16; k++) cycle();
    chk("two_frames_grants", 64'(gq.size()), 64'(16));
    en = 1'b0;
    for (int k = 0; k < 100 && (busy || pq.size() < 16); k++) cycle();
    chk_stream("twoframes", 16);
    chk("twoframes_idle", 64'(busy), 64'(0));
    clear();
    ready = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 12; k++) cycle();
    chk("stall_grants", 64'(gq.size()), 64'(4));
    chk("stall_req", 64'(req), 64'(0));
    chk("stall_valid", 64'(valid), 64'(1));
    chk("stall_head", 64'({data, px, py, sof, eol}), 64'({32'd0, 10'd0, 10'd0, 1'b1, 1'b0}));
    en = 1'b0;
    ready = 1'b1;
    for (int k = 0; k < 200 && (busy || pq.size() < 8); k++) cycle();
    chk_stream("stall", 8);
    clear();
    en = 1'b1;
    for (int k = 0; k < 20 && !(req && addr == 3'd2); k++) cycle();
    chk("gnt_wait_addr", 64'(addr), 64'(2));
    gnt = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk($sformatf("gnt_wait_req%0d", k), 64'(req), 64'(1));
      chk($sformatf("gnt_wait_addr%0d", k), 64'(addr), 64'(2));
    end
    chk("gnt_wait_grants", 64'(gq.size()), 64'(2));
    gnt = 1'b1;
    for (int k = 0; k < 20 && gq.size() < 4; k++) cycle();
    chk("drop_en_grants", 64'(gq.size()), 64'(4));
    en = 1'b0;
    for (int k = 0; k < 200 && (busy || pq.size() < 8); k++) cycle();
    chk_stream("dropen", 8);
    chk("dropen_busy", 64'(busy), 64'(0));
    chk("dropen_req", 64'(req), 64'(0));
    chk("dropen_valid", 64'(valid), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/framebuffer_scanout.md
Name: framebuffer_scanout

Overview:
Read-side master of the framebuffer memory interface. Fetches stored pixels from main DRAM in raster order (addr = y*SCREEN_WIDTH + x) through the memory interconnect, buffers them in a credit-controlled FIFO, and streams them with x/y/frame markers to the display output stage. It pairs with the pixel-write path that fills the same linear framebuffer.

Parameters:
SCREEN_WIDTH, 640, pixels per line
SCREEN_HEIGHT, 480, lines per frame
COLOR_WIDTH, 32, pixel data width
FIFO_DEPTH, 16, pixel buffer entries (power of 2, >=2)
ADDR_W (localparam), $clog2(SCREEN_WIDTH*SCREEN_HEIGHT), memory address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_enable  in  1  run scanout continuously while high
o_mem_req  out  1  read request, held until granted
o_mem_addr  out  ADDR_W  pixel address of the current request
i_mem_gnt  in  1  interconnect accepted the request this cycle
i_mem_rvalid  in  1  read data returned (in request order)
i_mem_rdata  in  COLOR_WIDTH  returned pixel
o_pix_valid  out  1  output pixel available
i_pix_ready  in  1  downstream consumes pixel
o_pix_data  out  COLOR_WIDTH  pixel colour
o_pix_x  out  10  column of o_pix_data
o_pix_y  out  10  row of o_pix_data
o_pix_sof  out  1  pixel is (0,0)
o_pix_eol  out  1  pixel is last of its line
o_busy  out  1  FSM not IDLE

Behaviour:
- Single clock domain. Reset is asynchronous, active-low on rst_n. All state is cleared: FSM=IDLE, issue address=0, outstanding=0, FIFO empty, output x/y=0. In reset, o_mem_req=0, o_mem_addr=0, o_pix_valid=0, o_busy=0, and o_pix_data=0.
- FSM IDLE: if i_enable=1, go to FETCH with issue address 0. o_mem_req rises on the cycle after i_enable is sampled high.
- FSM FETCH: o_mem_req=1 whenever a request is pending, or when (fifo_count + outstanding) < FIFO_DEPTH.
  - While o_mem_req=1 without i_mem_gnt, the address must stay stable and o_mem_req stays high. A request is never withdrawn.
  - On req&&gnt: outstanding+1 and address+1.
  - When the grant for address SCREEN_WIDTH*SCREEN_HEIGHT-1 occurs, go to DRAIN. o_mem_req is 0 in the following cycle.
- FSM DRAIN: no requests. When outstanding==0 (all data returned): if i_enable=1, go to FETCH at address 0 (back-to-back frames); otherwise go to IDLE.
- Deasserting i_enable mid-frame does not abort the frame. The current frame completes, then the FSM goes to IDLE.
- i_mem_rvalid: push i_mem_rdata into the FIFO and decrement outstanding. A grant and an rvalid in the same cycle leave outstanding unchanged.
- The credit rule guarantees rvalid never arrives while the FIFO is full. If it does, the data is dropped (assertion in simulation).
- FIFO is first-word fall-through. o_pix_valid = !empty. Data returned by rvalid in cycle t is visible at o_pix_valid in cycle t+1. A push and a pop in the same cycle are both honoured.
- Pop on o_pix_valid&&i_pix_ready. Output counters advance on each pop:
  - x+1.
  - At x=SCREEN_WIDTH-1: x wraps to 0 and y+1.
  - At the last pixel of the frame: y wraps to 0.
- o_pix_sof = valid && x==0 && y==0. o_pix_eol = valid && x==SCREEN_WIDTH-1. Both are combinational from the counters and flags.
- o_pix_data, o_pix_x, o_pix_y are stable while valid && !ready.
- Address arithmetic: compute y*SCREEN_WIDTH + x internally at ADDR_W+1 bits and truncate to ADDR_W. The issue address is an incrementing counter, not a multiply.

Optional Feature:
FB_SCANOUT_DOUBLE_BUFFER_EN
- When defined, the block adds input i_front_sel (1 bit).
- o_mem_addr widens to ADDR_W+1 bits. Its MSB is a front-buffer select latched on every transition into FETCH at address 0, so it is constant for a whole frame.
- Changing i_front_sel mid-frame takes effect only at the next frame start.
- When not defined, there is no i_front_sel port and o_mem_addr is ADDR_W bits, reading a single buffer.

Test Plan:
(Parameters: SCREEN_WIDTH=4, SCREEN_HEIGHT=2, FIFO_DEPTH=4.)
1. Reset mid-FETCH with 2 requests outstanding, i_enable held high. Required: o_mem_req=0, o_pix_valid=0, o_busy=0 during reset. After release, FSM returns to FETCH and the first request uses addr 0.
2. Memory grants immediately; rdata=addr returned 2 cycles later; i_pix_ready=1. Required: 8 requests at addr 0..7. Output data 0..7 with (x,y) = (0,0)..(3,1). sof on data 0 only; eol on data 3 and 7.
3. i_pix_ready=0 for the whole frame. Required: exactly 4 grants, then o_mem_req=0. After ready rises, pixels resume in order with no loss or duplication.
4. i_mem_gnt low for 5 cycles on addr 2. Required: o_mem_req stays 1 and o_mem_addr stays 2 throughout; addr 3 is issued only after the grant.
5. i_enable held high across two frames. Required: after the addr 7 data returns, the next request is addr 0. Output shows y wrap from 1 to 0 with sof asserted.
6. i_enable dropped after the addr 3 grant. Required: addrs 4..7 are still issued, all 8 pixels are output, then FSM goes to IDLE and o_busy=0.
